sensor_conditioner: RTL
=======================

# sensor_conditioner

Front-end conditioning stage for the two-road traffic light controller. Takes the raw, asynchronous vehicle-presence inputs for road A and road B. Synchronizes each into the `clk` domain and debounces it, then drives the controller's clean `sA`/`sB` sensor inputs. Raw glitches shorter than the debounce window never reach the controller FSM.

## Interface
- `DEB_CYCLES`, default 4: number of consecutive identical synchronized samples required to change an output; legal range 1..255.
- `CW`, default `$clog2(DEB_CYCLES+1)`: debounce counter width; derived, never overridden.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `rawA`  in  1  raw road-A vehicle sensor, asynchronous to `clk`.
- `rawB`  in  1  raw road-B vehicle sensor, asynchronous to `clk`.
- `sA`  out  1  debounced road-A presence, registered; feeds the controller's `sA`.
- `sB`  out  1  debounced road-B presence, registered; feeds the controller's `sB`.
- `clr_cnt`  in  1  synchronous clear of both vehicle counters (`CAR_COUNT_EN` only).
- `countA`  out  8  road-A vehicle count, saturating (`CAR_COUNT_EN` only).
- `countB`  out  8  road-B vehicle count, saturating (`CAR_COUNT_EN` only).

## Operation
- Each channel is independent and identical: a 2-flop synchronizer (`sync1`, `sync2`), a 4-state FSM and a `CW`-bit counter `cnt`.
- FSM states:
  - `S_IDLE`: output 0.
  - `S_RISE`: output 0, qualifying a 1.
  - `S_ON`: output 1.
  - `S_FALL`: output 1, qualifying a 0.
- `S_IDLE`:
  - `sync2`=1 moves to `S_RISE` with `cnt`=1.
  - If `DEB_CYCLES`=1, `sync2`=1 goes directly to `S_ON` instead.
- `S_RISE`:
  - `sync2`=0 returns to `S_IDLE`, `cnt`=0.
  - `sync2`=1 with `cnt`=`DEB_CYCLES`-1 moves to `S_ON`.
  - Otherwise `cnt`++.
- `S_ON`:
  - `sync2`=0 moves to `S_FALL` with `cnt`=1.
  - If `DEB_CYCLES`=1, `sync2`=0 goes directly to `S_IDLE` instead.
- `S_FALL`:
  - `sync2`=1 returns to `S_ON`, `cnt`=0.
  - `sync2`=0 with `cnt`=`DEB_CYCLES`-1 moves to `S_IDLE`.
  - Otherwise `cnt`++.
- Output is a registered flop set/cleared on the same edge as the `S_RISE`→`S_ON` / `S_FALL`→`S_IDLE` transition; no combinational path from `raw*` to `s*`.
- `cnt` never exceeds `DEB_CYCLES`-1; no wrap-around.
- Channels A and B changing on the same edge are handled independently; no arbitration.

## Timing
- Reset values:
  - `sync1`, `sync2`: 0.
  - FSM state: `S_IDLE`.
  - `cnt`: 0.
  - `sA`, `sB`: 0.
  - `countA`, `countB`: 0.
- Reset acts immediately and asynchronously, including mid-qualification and while `S_ON`. After reset deassertion, a raw input still held high is re-qualified from scratch.
- Rise latency: `raw` stable high before edge k gives `sync2`=1 after edge k+1. The output goes high on edge k+`DEB_CYCLES`+1, i.e. `DEB_CYCLES`+2 edges counting edge k. With the default of 4, that is 6 edges.
- Fall latency is identical.
- Any raw pulse or dropout seen by `sync2` for fewer than `DEB_CYCLES` consecutive samples produces no output change.

## Configuration
- Macro: `CAR_COUNT_EN`.
- Defined:
  - Ports `clr_cnt`, `countA` and `countB` exist.
  - Each counter increments on the edge its channel's output goes 0→1.
  - Counters saturate at 255.
  - `clr_cnt`=1 zeroes both counters on the next edge.
  - If a clear and an increment happen on the same edge, the clear wins and the result is 0.
- Undefined: ports and counters are absent; debounce behaviour is unchanged.

## Structure
- Shared package `tls_pkg`:
  - Channel state enum `sens_state_t` {`S_IDLE`, `S_RISE`, `S_ON`, `S_FALL`}.
  - Count width constant `CNT_W` = 8.
  - Count maximum `CNT_MAX` = 255.
- Sub-module `sensor_debounce`: one channel, containing the synchronizer, FSM, `cnt`, output flop and optional counter. It is instantiated twice in `sensor_conditioner`, which is otherwise wiring only.

## Test plan
All scenarios use `DEB_CYCLES`=4 and a 10 ns clock.
- Reset held 2 cycles with `rawA`=`rawB`=1 → `sA`=`sB`=0 during reset. After release, both rise together 6 edges later.
- `rawA`=1 for 1 cycle, then 0; then `rawA`=1 for 3 cycles, then 0 → `sA` stays 0 throughout.
- `rawA`=1 held 10 cycles → `sA` rises on the 6th edge after `rawA` rose. `rawA`→0 → `sA` falls exactly 6 edges later.
- `sA`=1 steady, `rawA` drops for 2 cycles then returns → `sA` stays 1. `rawB` pulsed for 5 cycles in the same window → `sB` goes high independently.
- `reset` asserted asynchronously mid-clock while `sB`=1 → `sB`=0 within the same cycle, before the next edge.
- `CAR_COUNT_EN`: 300 qualified `rawA` pulses → `countA`=255. Then `clr_cnt` on the same edge as a new `sA` rise → `countA`=0.

Source files
------------

// File: rtl/tls_pkg.sv
// tls_pkg: shared types and constants for the traffic light sensor front end
package tls_pkg;
  typedef enum logic [1:0] {S_IDLE, S_RISE, S_ON, S_FALL} sens_state_t;
  localparam int CNT_W = 8;
  localparam int CNT_MAX = 255;
endpackage

// File: rtl/sensor_debounce.sv
// sensor_debounce: one sensor channel (synchronizer, qualify FSM, registered output)
// Optional saturating vehicle counter when CAR_COUNT_EN is defined.
module sensor_debounce
  import tls_pkg::*;
#(
  parameter int DEB_CYCLES = 4,
  localparam int CW = $clog2(DEB_CYCLES + 1)
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
`ifdef CAR_COUNT_EN
  input  logic clr_cnt,
  output logic [CNT_W-1:0] count,
`endif
  output logic s
);
  localparam bit ONE = DEB_CYCLES == 1;
  logic sync1, sync2, hit, on_n;
  logic [CW-1:0] cnt, cnt_n;
  sens_state_t state, state_n;
  assign hit = cnt == CW'(DEB_CYCLES - 1);
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    case (state)
      S_IDLE: if (sync2) begin
        state_n = ONE ? S_ON : S_RISE;
        cnt_n = ONE ? '0 : CW'(1);
      end
      S_RISE: begin
        state_n = !sync2 ? S_IDLE : hit ? S_ON : S_RISE;
        cnt_n = (!sync2 || hit) ? '0 : cnt + CW'(1);
      end
      S_ON: if (!sync2) begin
        state_n = ONE ? S_IDLE : S_FALL;
        cnt_n = ONE ? '0 : CW'(1);
      end
      S_FALL: begin
        state_n = sync2 ? S_ON : hit ? S_IDLE : S_FALL;
        cnt_n = (sync2 || hit) ? '0 : cnt + CW'(1);
      end
      default: begin
        state_n = S_IDLE;
        cnt_n = '0;
      end
    endcase
  end
  // output flop follows the qualified state, so it changes on the transition edge
  assign on_n = state_n == S_ON || state_n == S_FALL;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      state <= S_IDLE;
      cnt <= '0;
      s <= 1'b0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      state <= state_n;
      cnt <= cnt_n;
      s <= on_n;
    end
`ifdef CAR_COUNT_EN
  always_ff @(posedge clk or posedge reset)
    if (reset) count <= '0;
    else count <= clr_cnt ? '0 : (on_n && !s && count != CNT_W'(CNT_MAX)) ? count + CNT_W'(1) : count;
`endif
endmodule

// File: rtl/sensor_conditioner.sv
// sensor_conditioner: debounced road A/B vehicle sensors for the light controller
// Optional vehicle counters when CAR_COUNT_EN is defined.
module sensor_conditioner
  import tls_pkg::*;
#(
  parameter int DEB_CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic rawA,
  input  logic rawB,
`ifdef CAR_COUNT_EN
  input  logic clr_cnt,
  output logic [CNT_W-1:0] countA,
  output logic [CNT_W-1:0] countB,
`endif
  output logic sA,
  output logic sB
);
  sensor_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_a (
    .clk(clk), .reset(reset), .raw(rawA),
`ifdef CAR_COUNT_EN
    .clr_cnt(clr_cnt), .count(countA),
`endif
    .s(sA)
  );
  sensor_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_b (
    .clk(clk), .reset(reset), .raw(rawB),
`ifdef CAR_COUNT_EN
    .clr_cnt(clr_cnt), .count(countB),
`endif
    .s(sB)
  );
endmodule
